vid_blob_tracker: RTL and testbench

VID_BLOB_TRACKER -- requirements
Module: vid_blob_tracker

---
 rtl/vid_blob_pkg.sv | 45 ++++
 rtl/vid_blob_class.sv | 101 ++++++++++
 rtl/vid_blob_tracker.sv | 262 ++++++++++++++++++++++++++
 tb/tb_vid_blob_tracker.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_blob_pkg.sv
// ============================================================
// vid_blob_pkg : shared encodings for the blob tracker
// Revision: 1.0
// ============================================================
`default_nettype none

package vid_blob_pkg;

    localparam int COORD_W = 11;
    localparam int COUNT_W = 19;
    localparam int FCNT_W  = 16;

    localparam logic [1:0] MODE_PASS   = 2'd0;
    localparam logic [1:0] MODE_HILITE = 2'd1;
    localparam logic [1:0] MODE_MASK   = 2'd2;

    localparam logic [3:0] PKT_VIDEO = 4'h0;

    localparam logic [5:0] ADDR_CTRL   = 6'd0;
    localparam logic [5:0] ADDR_STATUS = 6'd1;
    localparam logic [5:0] ADDR_CLEAR  = 6'd2;
    localparam int         CH_BASE     = 8;
    localparam int         CH_STRIDE   = 8;

    localparam logic [2:0] OFF_LO     = 3'd0;
    localparam logic [2:0] OFF_HI     = 3'd1;
    localparam logic [2:0] OFF_COLOUR = 3'd2;
    localparam logic [2:0] OFF_BMIN   = 3'd3;
    localparam logic [2:0] OFF_BMAX   = 3'd4;
    localparam logic [2:0] OFF_RESULT = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VIDEO = 2'd1,
        ST_CTRL  = 2'd2
    } pkt_state_t;

    function automatic logic [31:0] pack_xy(input logic [COORD_W-1:0] x,
                                            input logic [COORD_W-1:0] y);
        return {5'd0, y, 5'd0, x};
    endfunction

endpackage

`default_nettype wire

// File: rtl/vid_blob_class.sv
// ============================================================
// vid_blob_class : one colour class - range compare, count, bbox
// Revision: 1.0
// ============================================================
`default_nettype none

module vid_blob_class
    import vid_blob_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init,
    input  logic                  pix_en,
    input  logic                  latch,
    input  logic [3*DATA_W-1:0]   pixel,
    input  logic [3*DATA_W-1:0]   lo,
    input  logic [3*DATA_W-1:0]   hi,
    input  logic [COORD_W-1:0]    x,
    input  logic [COORD_W-1:0]    y,
    output logic                  match,
    output logic                  res_valid,
    output logic [COUNT_W-1:0]    res_count,
    output logic [COORD_W-1:0]    res_min_x,
    output logic [COORD_W-1:0]    res_min_y,
    output logic [COORD_W-1:0]    res_max_x,
    output logic [COORD_W-1:0]    res_max_y
);

    localparam logic [COORD_W-1:0] X_INIT = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_INIT = COORD_W'(IMG_H - 1);

    logic [COUNT_W-1:0] cnt, cnt_nxt;
    logic [COORD_W-1:0] min_x, min_y, max_x, max_y;
    logic [COORD_W-1:0] min_x_nxt, min_y_nxt, max_x_nxt, max_y_nxt;
    logic               hit;

    always_comb begin
        match = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (pixel[k*DATA_W +: DATA_W] < lo[k*DATA_W +: DATA_W] ||
                pixel[k*DATA_W +: DATA_W] > hi[k*DATA_W +: DATA_W])
                match = 1'b0;
        end
    end

    assign hit = pix_en & match;

    // Next-state values include the current pixel so the EOP beat is counted when latched
    always_comb begin
        cnt_nxt   = (hit && cnt != '1) ? cnt + 1'b1 : cnt;
        min_x_nxt = (hit && x < min_x) ? x : min_x;
        min_y_nxt = (hit && y < min_y) ? y : min_y;
        max_x_nxt = (hit && x > max_x) ? x : max_x;
        max_y_nxt = (hit && y > max_y) ? y : max_y;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            min_x     <= X_INIT;
            min_y     <= Y_INIT;
            max_x     <= '0;
            max_y     <= '0;
            res_valid <= 1'b0;
            res_count <= '0;
            res_min_x <= '0;
            res_min_y <= '0;
            res_max_x <= '0;
            res_max_y <= '0;
        end else begin
            if (init) begin
                cnt   <= '0;
                min_x <= X_INIT;
                min_y <= Y_INIT;
                max_x <= '0;
                max_y <= '0;
            end else begin
                cnt   <= cnt_nxt;
                min_x <= min_x_nxt;
                min_y <= min_y_nxt;
                max_x <= max_x_nxt;
                max_y <= max_y_nxt;
            end
            if (latch) begin
                res_valid <= (cnt_nxt != '0);
                res_count <= cnt_nxt;
                res_min_x <= (cnt_nxt == '0) ? '0 : min_x_nxt;
                res_min_y <= (cnt_nxt == '0) ? '0 : min_y_nxt;
                res_max_x <= (cnt_nxt == '0) ? '0 : max_x_nxt;
                res_max_y <= (cnt_nxt == '0) ? '0 : max_y_nxt;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vid_blob_tracker.sv
// ============================================================
// vid_blob_tracker : colour-class blob tracker on Avalon-ST video
// Revision: 1.0
// ============================================================
`default_nettype none

module vid_blob_tracker
    import vid_blob_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [3*DATA_W-1:0]   sink_data,
    input  logic                  sink_valid,
    input  logic                  sink_startofpacket,
    input  logic                  sink_endofpacket,
    output logic                  sink_ready,
    output logic [3*DATA_W-1:0]   source_data,
    output logic                  source_valid,
    output logic                  source_startofpacket,
    output logic                  source_endofpacket,
    input  logic                  source_ready,
    input  logic [5:0]            s_address,
    input  logic                  s_read,
    input  logic                  s_write,
    input  logic [31:0]           s_writedata,
    output logic [31:0]           s_readdata
);

    localparam int PIX_W  = 3 * DATA_W;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int PCNT_W = $clog2(NPIX + 1) + 1;
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(IMG_H - 1);
    localparam logic [PCNT_W-1:0]  NPIX_C   = PCNT_W'(NPIX);
    localparam logic [PCNT_W-1:0]  NPIX_M1  = PCNT_W'(NPIX - 1);
    localparam logic [2:0]         NCH3     = 3'(NUM_CH);

    pkt_state_t state, state_nxt;

    logic              accept, vid_sop, pix_en, vid_eop;
    logic [COORD_W-1:0] x, y;
    logic [PCNT_W-1:0]  pix_cnt;
    logic               flag_short, flag_overrun;
    logic [FCNT_W-1:0]  frame_cnt;
    logic [1:0]         ctrl, mode_sh;

    logic [PIX_W-1:0]   lo    [NUM_CH];
    logic [PIX_W-1:0]   hi    [NUM_CH];
    logic [PIX_W-1:0]   col   [NUM_CH];
    logic [PIX_W-1:0]   lo_sh [NUM_CH];
    logic [PIX_W-1:0]   hi_sh [NUM_CH];
    logic [PIX_W-1:0]   col_sh[NUM_CH];

    logic [NUM_CH-1:0]  match;
    logic               res_valid [NUM_CH];
    logic [COUNT_W-1:0] res_count [NUM_CH];
    logic [COORD_W-1:0] res_min_x [NUM_CH];
    logic [COORD_W-1:0] res_min_y [NUM_CH];
    logic [COORD_W-1:0] res_max_x [NUM_CH];
    logic [COORD_W-1:0] res_max_y [NUM_CH];

    logic [PIX_W-1:0]   out_pix;
    logic [31:0]        rd_nxt;
    logic [5:0]         ch_rel;
    logic [2:0]         ch_idx, ch_off;
    logic               ch_hit;
    logic               unused_bits;

    assign sink_ready = source_ready | ~source_valid;
    assign accept     = sink_valid & sink_ready;
    assign vid_sop    = accept & sink_startofpacket & (sink_data[3:0] == PKT_VIDEO);
    assign pix_en     = accept & ~sink_startofpacket & (state == ST_VIDEO);
    assign vid_eop    = pix_en & sink_endofpacket;

    assign ch_rel      = s_address - 6'(CH_BASE);
    assign ch_idx      = ch_rel[5:3];
    assign ch_off      = ch_rel[2:0];
    assign ch_hit      = (s_address >= 6'(CH_BASE)) && (ch_idx < NCH3);
    assign unused_bits = ^s_writedata[31:PIX_W];

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) state <= ST_IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (sink_startofpacket) begin
                if (sink_endofpacket)
                    state_nxt = ST_IDLE;
                else if (sink_data[3:0] == PKT_VIDEO)
                    state_nxt = ST_VIDEO;
                else
                    state_nxt = ST_CTRL;
            end else if (sink_endofpacket) begin
                state_nxt = ST_IDLE;
            end
        end
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            vid_blob_class #(
                .DATA_W (DATA_W),
                .IMG_W  (IMG_W),
                .IMG_H  (IMG_H)
            ) u_class (
                .clk       (clk_clk),
                .rst_n     (reset_reset_n),
                .init      (vid_sop),
                .pix_en    (pix_en),
                .latch     (vid_eop),
                .pixel     (sink_data),
                .lo        (lo_sh[c]),
                .hi        (hi_sh[c]),
                .x         (x),
                .y         (y),
                .match     (match[c]),
                .res_valid (res_valid[c]),
                .res_count (res_count[c]),
                .res_min_x (res_min_x[c]),
                .res_min_y (res_min_y[c]),
                .res_max_x (res_max_x[c]),
                .res_max_y (res_max_y[c])
            );
        end
    endgenerate

    always_comb begin
        out_pix = sink_data;
        if (pix_en) begin
            case (mode_sh)
                MODE_HILITE: begin
                    // Descending scan leaves the lowest-index match in place
                    for (int c = NUM_CH - 1; c >= 0; c--) begin
                        if (match[c]) out_pix = col_sh[c];
                    end
                end
                MODE_MASK: if (match == '0) out_pix = '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            source_valid         <= 1'b0;
            source_data          <= '0;
            source_startofpacket <= 1'b0;
            source_endofpacket   <= 1'b0;
        end else if (accept) begin
            source_valid         <= 1'b1;
            source_data          <= out_pix;
            source_startofpacket <= sink_startofpacket;
            source_endofpacket   <= sink_endofpacket;
        end else if (source_ready) begin
            source_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            x       <= '0;
            y       <= '0;
            pix_cnt <= '0;
        end else if (vid_sop) begin
            x       <= '0;
            y       <= '0;
            pix_cnt <= '0;
        end else if (pix_en) begin
            if (pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
            if (x == X_LAST) begin
                x <= '0;
                if (y != Y_LAST) y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            ctrl         <= MODE_PASS;
            mode_sh      <= MODE_PASS;
            flag_short   <= 1'b0;
            flag_overrun <= 1'b0;
            frame_cnt    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                lo[c]     <= '1;
                hi[c]     <= '0;
                col[c]    <= '0;
                lo_sh[c]  <= '1;
                hi_sh[c]  <= '0;
                col_sh[c] <= '0;
            end
        end else begin
            if (s_write && s_address == ADDR_CTRL) ctrl <= s_writedata[1:0];
            if (s_write && s_address == ADDR_CLEAR && s_writedata[0]) begin
                flag_short   <= 1'b0;
                flag_overrun <= 1'b0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (s_write && ch_hit && ch_idx == 3'(c)) begin
                    if (ch_off == OFF_LO)     lo[c]  <= s_writedata[PIX_W-1:0];
                    if (ch_off == OFF_HI)     hi[c]  <= s_writedata[PIX_W-1:0];
                    if (ch_off == OFF_COLOUR) col[c] <= s_writedata[PIX_W-1:0];
                end
            end
            if (vid_sop) begin
                mode_sh <= ctrl;
                for (int c = 0; c < NUM_CH; c++) begin
                    lo_sh[c]  <= lo[c];
                    hi_sh[c]  <= hi[c];
                    col_sh[c] <= col[c];
                end
            end
            // A pixel beyond the nominal frame size means y had nowhere left to go
            if (pix_en && pix_cnt >= NPIX_C) flag_overrun <= 1'b1;
            if (vid_eop) begin
                frame_cnt <= frame_cnt + 1'b1;
                if (pix_cnt < NPIX_M1) flag_short <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_nxt = '0;
        if (s_address == ADDR_CTRL) begin
            rd_nxt = {30'd0, ctrl};
        end else if (s_address == ADDR_STATUS) begin
            rd_nxt = {14'd0, flag_short, flag_overrun, frame_cnt};
        end else if (ch_hit) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_idx == 3'(c)) begin
                    case (ch_off)
                        OFF_LO:     rd_nxt = 32'(lo[c]);
                        OFF_HI:     rd_nxt = 32'(hi[c]);
                        OFF_COLOUR: rd_nxt = 32'(col[c]);
                        OFF_BMIN:   rd_nxt = pack_xy(res_min_x[c], res_min_y[c]);
                        OFF_BMAX:   rd_nxt = pack_xy(res_max_x[c], res_max_y[c]);
                        OFF_RESULT: rd_nxt = {res_valid[c], 12'd0, res_count[c]};
                        default:    rd_nxt = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n)  s_readdata <= '0;
        else if (s_read)     s_readdata <= rd_nxt;
    end

endmodule

`default_nettype wire

// File: tb/tb_vid_blob_tracker.sv
// ============================================================
// tb_vid_blob_tracker : directed checks for vid_blob_tracker
// Revision: 1.0
// ============================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vid_blob_tracker;

    localparam int DW   = 8;
    localparam int NCH  = 4;
    localparam int W    = 112;
    localparam int H    = 72;
    localparam int NPIX = W * H;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [23:0] sink_data;
    logic        sink_valid, sink_startofpacket, sink_endofpacket, sink_ready;
    logic [23:0] source_data;
    logic        source_valid, source_startofpacket, source_endofpacket;
    logic        source_ready;
    logic [5:0]  s_address;
    logic        s_read, s_write;
    logic [31:0] s_writedata, s_readdata;

    always #5 clk_clk = ~clk_clk;

    vid_blob_tracker #(
        .DATA_W (DW),
        .NUM_CH (NCH),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk_clk              (clk_clk),
        .reset_reset_n        (reset_reset_n),
        .sink_data            (sink_data),
        .sink_valid           (sink_valid),
        .sink_startofpacket   (sink_startofpacket),
        .sink_endofpacket     (sink_endofpacket),
        .sink_ready           (sink_ready),
        .source_data          (source_data),
        .source_valid         (source_valid),
        .source_startofpacket (source_startofpacket),
        .source_endofpacket   (source_endofpacket),
        .source_ready         (source_ready),
        .s_address            (s_address),
        .s_read               (s_read),
        .s_write              (s_write),
        .s_writedata          (s_writedata),
        .s_readdata           (s_readdata)
    );

    int vectors     = 0;
    int miscompares = 0;
    int beat_errs   = 0;
    int green_cnt   = 0;
    bit mon_en      = 1'b0;
    bit rnd_ready   = 1'b0;
    int wr_idx      = -1;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [25:0] expq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Red rectangle at x=100..109, y=50..69 plus two near-miss pixels on its edge
    function automatic logic [23:0] pix_at(input int x, input int y);
        if (x >= 100 && x <= 109 && y >= 50 && y <= 69)
            return {8'(200 + 5 * (x - 100)), 8'(12 + 2 * (y - 50)), 8'd40};
        if (x == 99 && y == 50)  return 24'hC70A0A;
        if (x == 110 && y == 50) return 24'hC8330A;
        return {8'(x), 8'(y), 8'h80};
    endfunction

    function automatic logic [23:0] exp_hl(input int x, input int y, input logic [23:0] p);
        if (x >= 100 && x <= 109 && y >= 50 && y <= 69) return 24'h00FF00;
        if (x == 110 && y == 50) return 24'h0000FF;
        return p;
    endfunction

    initial begin
        source_ready = 1'b1;
        forever begin
            @(posedge clk_clk);
            #1;
            source_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        logic [25:0] e;
        forever begin
            @(negedge clk_clk);
            if (mon_en && source_valid && source_ready) begin
                if (expq.size() == 0) begin
                    beat_errs++;
                end else begin
                    e = expq.pop_front();
                    if ({source_startofpacket, source_endofpacket, source_data} !== e) beat_errs++;
                end
                if (source_data == 24'h00FF00 && !source_startofpacket) green_cnt++;
            end
        end
    end

    task automatic send(input logic [23:0] d, input logic sop, input logic eop, input logic [23:0] e);
        int t;
        t = 0;
        sink_data = d;
        sink_startofpacket = sop;
        sink_endofpacket = eop;
        sink_valid = 1'b1;
        @(negedge clk_clk);
        while (!sink_ready && t < 1000) begin
            t++;
            @(negedge clk_clk);
        end
        if (!sink_ready) chk("sink_ready_timeout", 32'd0, 32'd1);
        else             expq.push_back({sop, eop, e});
        @(posedge clk_clk);
        #1;
        sink_valid = 1'b0;
    endtask

    task automatic send_frame(input int npix, input int mode);
        send(24'h000000, 1'b1, 1'b0, 24'h000000);
        for (int i = 0; i < npix; i++) begin
            int x;
            int y;
            logic [23:0] p;
            logic [23:0] e;
            x = i % W;
            y = i / W;
            p = pix_at(x, y);
            e = (mode == 1) ? exp_hl(x, y, p) : p;
            if (i == wr_idx) begin
                s_address = wr_addr;
                s_writedata = wr_data;
                s_write = 1'b1;
            end
            send(p, 1'b0, (i == npix - 1), e);
            s_write = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (expq.size() != 0 && t < 200) begin
            @(posedge clk_clk);
            t++;
        end
        #1;
        chk({tag, "_beats_left"}, expq.size(), 0);
        chk({tag, "_beat_errs"}, beat_errs, 0);
        beat_errs = 0;
    endtask

    task automatic mm_write(input logic [5:0] a, input logic [31:0] d);
        s_address = a;
        s_writedata = d;
        s_write = 1'b1;
        @(posedge clk_clk);
        #1;
        s_write = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
        s_address = a;
        s_read = 1'b1;
        @(posedge clk_clk);
        #1;
        s_read = 1'b0;
        chk(tag, s_readdata, exp);
    endtask

    task automatic config_ch0();
        mm_write(6'd8,  32'h00C80000);
        mm_write(6'd9,  32'h00FF3232);
        mm_write(6'd10, 32'h0000FF00);
    endtask

    initial begin
        reset_reset_n = 1'b0;
        sink_data = '0;
        sink_valid = 1'b0;
        sink_startofpacket = 1'b0;
        sink_endofpacket = 1'b0;
        s_address = '0;
        s_read = 1'b0;
        s_write = 1'b0;
        s_writedata = '0;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) @(posedge clk_clk);
        #1;
        reset_reset_n = 1'b1;

        @(negedge clk_clk);
        chk("rst_source_valid", 32'(source_valid), 32'd0);
        chk("rst_source_data", 32'(source_data), 32'd0);
        chk("rst_sink_ready", 32'(sink_ready), 32'd1);
        @(posedge clk_clk);
        #1;
        rd_chk("rst_status", 6'd1, 32'h0);
        rd_chk("rst_ctrl", 6'd0, 32'h0);
        rd_chk("rst_lo0", 6'd8, 32'h00FFFFFF);
        rd_chk("rst_hi0", 6'd9, 32'h0);
        rd_chk("rst_res0", 6'd13, 32'h0);
        rd_chk("unmapped_63", 6'd63, 32'h0);
        rd_chk("unmapped_ch0_6", 6'd14, 32'h0);

        config_ch0();
        mm_write(6'd16, 32'h00C80000);
        mm_write(6'd17, 32'h00FFFFFF);
        mm_write(6'd18, 32'h000000FF);

        mon_en = 1'b1;
        send_frame(NPIX, 0);
        drain("frameA");
        rd_chk("A_bmin0", 6'd11, 32'h00320064);
        rd_chk("A_bmax0", 6'd12, 32'h0045006D);
        rd_chk("A_res0", 6'd13, 32'h800000C8);
        rd_chk("A_res1", 6'd21, 32'h800000C9);
        rd_chk("A_bmax1", 6'd20, 32'h0045006E);
        rd_chk("A_status", 6'd1, 32'h00000001);

        mm_write(6'd0, 32'd1);
        green_cnt = 0;
        send_frame(NPIX, 1);
        drain("frameB_hl");
        chk("B_green_cnt", green_cnt, 200);
        rd_chk("B_status", 6'd1, 32'h00000002);

        send(24'h00000F, 1'b1, 1'b0, 24'h00000F);
        send(24'hE61428, 1'b0, 1'b0, 24'hE61428);
        send(24'h123456, 1'b0, 1'b1, 24'h123456);
        drain("ctrl_pkt");
        rd_chk("ctrl_status", 6'd1, 32'h00000002);
        rd_chk("ctrl_res0", 6'd13, 32'h800000C8);

        mm_write(6'd0, 32'd0);
        rnd_ready = 1'b1;
        send_frame(NPIX, 0);
        drain("frameC_stall");
        rnd_ready = 1'b0;
        rd_chk("C_status", 6'd1, 32'h00000003);
        rd_chk("C_res0", 6'd13, 32'h800000C8);

        wr_idx = 2000;
        wr_addr = 6'd9;
        wr_data = 32'h00FF1E32;
        send_frame(NPIX, 0);
        wr_idx = -1;
        drain("frameD");
        rd_chk("D_res0_oldhi", 6'd13, 32'h800000C8);
        rd_chk("D_bmax0", 6'd12, 32'h0045006D);
        send_frame(NPIX, 0);
        drain("frameE");
        rd_chk("E_res0_newhi", 6'd13, 32'h80000064);
        rd_chk("E_bmax0", 6'd12, 32'h003B006D);
        rd_chk("E_status", 6'd1, 32'h00000005);

        mon_en = 1'b0;
        send(24'h000000, 1'b1, 1'b0, 24'h000000);
        for (int i = 0; i < 500; i++) send(pix_at(i % W, i / W), 1'b0, 1'b0, 24'h0);
        sink_data = 24'h808080;
        sink_valid = 1'b1;
        reset_reset_n = 1'b0;
        repeat (2) @(posedge clk_clk);
        #1;
        sink_valid = 1'b0;
        @(negedge clk_clk);
        chk("midrst_source_valid", 32'(source_valid), 32'd0);
        chk("midrst_source_data", 32'(source_data), 32'd0);
        chk("midrst_source_sop", 32'(source_startofpacket), 32'd0);
        @(posedge clk_clk);
        #1;
        reset_reset_n = 1'b1;
        expq.delete();
        beat_errs = 0;
        mon_en = 1'b1;
        rd_chk("midrst_status", 6'd1, 32'h0);
        rd_chk("midrst_res0", 6'd13, 32'h0);

        config_ch0();
        send(24'hE61428, 1'b0, 1'b1, 24'hE61428);
        drain("stray_eop");
        rd_chk("stray_status", 6'd1, 32'h0);
        rd_chk("stray_res0", 6'd13, 32'h0);

        send_frame(1000, 0);
        drain("short");
        rd_chk("short_status", 6'd1, 32'h00020001);
        rd_chk("short_res0", 6'd13, 32'h0);
        rd_chk("short_bmin0", 6'd11, 32'h0);
        rd_chk("short_bmax0", 6'd12, 32'h0);
        mm_write(6'd2, 32'd1);
        rd_chk("clear_status", 6'd1, 32'h00000001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
